risco5_wb_adapter: RTL and testbench

RISCO5_WB_ADAPTER -- requirements
Module: risco5_wb_adapter

---
 rtl/risco5_mem_pkg.sv | 27 ++
 rtl/risco5_lane_align.sv | 44 ++++
 rtl/risco5_wb_adapter.sv | 160 ++++++++++++++++
 tb/tb_risco5_wb_adapter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/risco5_mem_pkg.sv
// Shared types and encodings for the RISC-V core to Wishbone memory adapter.
package risco5_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = DATA_W / 8;

  localparam logic [2:0] OPT_LB  = 3'b000;
  localparam logic [2:0] OPT_LH  = 3'b001;
  localparam logic [2:0] OPT_LW  = 3'b010;
  localparam logic [2:0] OPT_LBU = 3'b100;
  localparam logic [2:0] OPT_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Wishbone request payload held constant for the whole bus cycle.
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/risco5_lane_align.sv
// Byte-lane steering between the core (right-aligned data) and the 32-bit bus.
module risco5_lane_align
  import risco5_mem_pkg::*;
(
  input  logic [2:0]        option,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [SEL_W-1:0]  sel_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              misaligned_c
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted      = bus_rdata >> {lane, 3'b000};
    sel_c        = 4'b1111;
    wdata_c      = write_data;
    rdata_c      = bus_rdata;
    misaligned_c = 1'b0;
    // option[2] selects zero extension for the unsigned loads
    case (option[1:0])
      2'b00: begin
        sel_c   = 4'b0001 << lane;
        wdata_c = {4{write_data[7:0]}};
        rdata_c = option[2] ? DATA_W'(shifted[7:0])
                            : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        sel_c        = 4'b0011 << lane;
        wdata_c      = {2{write_data[15:0]}};
        rdata_c      = option[2] ? DATA_W'(shifted[15:0])
                                 : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
        misaligned_c = lane[0];
      end
      default: begin
        misaligned_c = |lane;
      end
    endcase
  end

endmodule

// File: rtl/risco5_wb_adapter.sv
// Single-outstanding core load/store port bridged onto a Wishbone classic master,
// with misalignment detection and an optional acknowledge timeout.
module risco5_wb_adapter
  import risco5_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic [2:0]        option,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              memory_response,
  output logic              bus_error,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [SEL_W-1:0]  wb_sel,
  output logic [DATA_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data_out,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              wb_ack
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  wb_req_t           wb_q, wb_d;
  logic [2:0]        opt_q, opt_d;
  logic [1:0]        lane_q, lane_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cyc_q, cyc_d;
  logic              resp_q, resp_d;
  logic              berr_q, berr_d;

  logic              req_c;
  logic              timeout_c;
  logic [2:0]        al_opt_c;
  logic [1:0]        al_lane_c;
  logic [SEL_W-1:0]  sel_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rdata_c;
  logic              mis_c;

  assign req_c     = memory_read | memory_write;
  assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Steer live inputs while idle, the latched request once a cycle is in flight
  assign al_opt_c  = (state_q == ST_IDLE) ? option       : opt_q;
  assign al_lane_c = (state_q == ST_IDLE) ? address[1:0] : lane_q;

  risco5_lane_align u_align (
    .option       (al_opt_c),
    .lane         (al_lane_c),
    .write_data   (write_data),
    .bus_rdata    (wb_data_in),
    .sel_c        (sel_c),
    .wdata_c      (wdata_c),
    .rdata_c      (rdata_c),
    .misaligned_c (mis_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_c) state_d = mis_c ? ST_DONE : ST_BUS;
      ST_BUS:  if (wb_ack || timeout_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched request
  always_comb begin
    opt_d   = opt_q;
    lane_d  = lane_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          opt_d   = option;
          lane_d  = address[1:0];
          we_d    = memory_write;
          err_d   = mis_c;
          cnt_d   = '0;
          wb_d    = '{we: memory_write, sel: sel_c,
                      addr: {address[DATA_W-1:2], 2'b00}, dat: wdata_c};
          if (mis_c) rdata_d = '0;
        end
      end
      ST_BUS: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (wb_ack) begin
          rdata_d = we_q ? '0 : rdata_c;
        end else if (timeout_c) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
    cyc_d  = (state_d == ST_BUS);
    resp_d = (state_d == ST_DONE);
    berr_d = resp_d & err_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opt_q   <= 3'b000;
      lane_q  <= 2'b00;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wb_q    <= '0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      resp_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      opt_q   <= opt_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      resp_q  <= resp_d;
      berr_q  <= berr_d;
    end
  end

  assign wb_cyc          = cyc_q;
  assign wb_stb          = cyc_q;
  assign wb_we           = wb_q.we;
  assign wb_sel          = wb_q.sel;
  assign wb_addr         = wb_q.addr;
  assign wb_data_out     = wb_q.dat;
  assign read_data       = rdata_q;
  assign memory_response = resp_q;
  assign bus_error       = berr_q;

endmodule

// File: tb/tb_risco5_wb_adapter.sv
// Directed bench for risco5_wb_adapter: stores, loads, misalignment, timeout, reset.
module tb_risco5_wb_adapter;
  import risco5_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memory_read = 1'b0, memory_write = 1'b0;
  logic [2:0]  option = 3'b000;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        memory_response, bus_error;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_addr, wb_data_out;
  logic [31:0] wb_data_in = '0;
  logic        wb_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  risco5_wb_adapter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .memory_read(memory_read), .memory_write(memory_write),
    .option(option), .address(address), .write_data(write_data),
    .read_data(read_data), .memory_response(memory_response), .bus_error(bus_error),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_addr(wb_addr), .wb_data_out(wb_data_out),
    .wb_data_in(wb_data_in), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle request, leaving the bench just after the accepting edge
  task automatic issue(input logic rd, input logic wr, input logic [2:0] opt,
                       input logic [31:0] addr, input logic [31:0] wd);
    memory_read = rd; memory_write = wr; option = opt; address = addr; write_data = wd;
    step();
    memory_read = 1'b0; memory_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin failures++; $display("FAIL rst_ctrl got=%b exp=000", {wb_cyc, wb_stb, wb_we}); end
    checks++; if ({memory_response, bus_error} !== 2'b00) begin failures++; $display("FAIL rst_resp got=%b exp=00", {memory_response, bus_error}); end
    checks++; if (wb_sel !== 4'b0000) begin failures++; $display("FAIL rst_sel got=%b exp=0000", wb_sel); end
    checks++; if ({wb_addr, wb_data_out, read_data} !== 96'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {wb_addr, wb_data_out, read_data}); end
    reset = 1'b0;
  endtask

  task automatic test_store();
    issue(1'b0, 1'b1, OPT_LB, 32'h0000_0102, 32'hAABB_CCDD);
    checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b111) begin failures++; $display("FAIL sb_ctrl got=%b exp=111", {wb_cyc, wb_stb, wb_we}); end
    checks++; if (wb_addr !== 32'h0000_0100) begin failures++; $display("FAIL sb_addr got=%h exp=00000100", wb_addr); end
    checks++; if (wb_sel !== 4'b0100) begin failures++; $display("FAIL sb_sel got=%b exp=0100", wb_sel); end
    checks++; if (wb_data_out !== 32'hDDDD_DDDD) begin failures++; $display("FAIL sb_dout got=%h exp=dddddddd", wb_data_out); end
    step();
    checks++; if (memory_response !== 1'b0) begin failures++; $display("FAIL sb_early_resp got=%b exp=0", memory_response); end
    step();
    checks++; if ({wb_cyc, wb_sel} !== 5'b1_0100) begin failures++; $display("FAIL sb_hold got=%b exp=10100", {wb_cyc, wb_sel}); end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    checks++; if ({memory_response, bus_error, wb_cyc} !== 3'b100) begin failures++; $display("FAIL sb_done got=%b exp=100", {memory_response, bus_error, wb_cyc}); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL sb_rdata got=%h exp=0", read_data); end
    step();
    checks++; if (memory_response !== 1'b0) begin failures++; $display("FAIL sb_pulse got=%b exp=0", memory_response); end
    issue(1'b0, 1'b1, OPT_LH, 32'h0000_0202, 32'h1234_ABCD);
    checks++; if ({wb_sel, wb_data_out} !== {4'b1100, 32'hABCD_ABCD}) begin failures++; $display("FAIL sh_lane got=%h exp=cabcdabcd", {wb_sel, wb_data_out}); end
    wb_ack = 1'b1; step(); wb_ack = 1'b0; step();
    issue(1'b0, 1'b1, OPT_LW, 32'h0000_0208, 32'h1234_ABCD);
    checks++; if ({wb_sel, wb_data_out, wb_addr} !== {4'b1111, 32'h1234_ABCD, 32'h0000_0208}) begin failures++; $display("FAIL sw_lane got=%h exp=f1234abcd00000208", {wb_sel, wb_data_out, wb_addr}); end
    wb_ack = 1'b1; step(); wb_ack = 1'b0; step();
  endtask

  task automatic test_load();
    logic [2:0]  opts  [4] = '{OPT_LH, OPT_LHU, OPT_LB, OPT_LBU};
    logic [31:0] addrs [4] = '{32'h202, 32'h202, 32'h203, 32'h201};
    logic [3:0]  sels  [4] = '{4'b1100, 4'b1100, 4'b1000, 4'b0010};
    logic [31:0] exps  [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80, 32'h0000_0012};
    wb_data_in = 32'h8001_1234;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, opts[i], addrs[i], 32'h0);
      checks++; if ({wb_we, wb_sel, wb_addr} !== {1'b0, sels[i], 32'h0000_0200}) begin failures++; $display("FAIL ld%0d_req got=%h exp=%h", i, {wb_we, wb_sel, wb_addr}, {1'b0, sels[i], 32'h0000_0200}); end
      wb_ack = 1'b1; step(); wb_ack = 1'b0;
      checks++; if ({memory_response, read_data} !== {1'b1, exps[i]}) begin failures++; $display("FAIL ld%0d_data got=%h exp=%h", i, {memory_response, read_data}, {1'b1, exps[i]}); end
      step();
    end
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, OPT_LW, 32'h0000_0301, 32'h0);
    checks++; if (wb_cyc !== 1'b0) begin failures++; $display("FAIL mis_lw_cyc got=%b exp=0", wb_cyc); end
    checks++; if ({memory_response, bus_error, read_data} !== {2'b11, 32'h0}) begin failures++; $display("FAIL mis_lw_resp got=%h exp=300000000", {memory_response, bus_error, read_data}); end
    step();
    checks++; if ({memory_response, bus_error, wb_cyc} !== 3'b000) begin failures++; $display("FAIL mis_lw_after got=%b exp=000", {memory_response, bus_error, wb_cyc}); end
    issue(1'b0, 1'b1, OPT_LH, 32'h0000_0201, 32'h0);
    checks++; if ({wb_cyc, memory_response, bus_error} !== 3'b011) begin failures++; $display("FAIL mis_sh got=%b exp=011", {wb_cyc, memory_response, bus_error}); end
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(1'b1, 1'b0, OPT_LW, 32'h0000_0400, 32'h0);
    while (wb_cyc === 1'b1 && n < 20) begin n++; step(); end
    checks++; if (n !== 8) begin failures++; $display("FAIL to_cycles got=%0d exp=8", n); end
    checks++; if ({memory_response, bus_error, read_data} !== {2'b11, 32'h0}) begin failures++; $display("FAIL to_resp got=%h exp=300000000", {memory_response, bus_error, read_data}); end
    step();
    checks++; if ({memory_response, bus_error} !== 2'b00) begin failures++; $display("FAIL to_after got=%b exp=00", {memory_response, bus_error}); end
  endtask

  task automatic test_back_to_back();
    int resp_seen = 0;
    issue(1'b0, 1'b1, OPT_LW, 32'h0000_0700, 32'hCAFE_F00D);
    checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL rb_cyc got=%b exp=1", wb_cyc); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({wb_cyc, wb_stb} !== 2'b00) begin failures++; $display("FAIL rb_drop got=%b exp=00", {wb_cyc, wb_stb}); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (memory_response === 1'b1) resp_seen++;
      step();
    end
    checks++; if (resp_seen !== 0) begin failures++; $display("FAIL rb_noresp got=%0d exp=0", resp_seen); end
    memory_read = 1'b1; option = OPT_LW; address = 32'h0000_0500;
    step();
    checks++; if ({wb_cyc, wb_addr} !== {1'b1, 32'h0000_0500}) begin failures++; $display("FAIL b2b_a_req got=%h exp=100000500", {wb_cyc, wb_addr}); end
    wb_data_in = 32'h1111_1111; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; address = 32'h0000_0504;
    checks++; if ({memory_response, read_data} !== {1'b1, 32'h1111_1111}) begin failures++; $display("FAIL b2b_a_data got=%h exp=111111111", {memory_response, read_data}); end
    step();
    checks++; if ({memory_response, wb_cyc} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {memory_response, wb_cyc}); end
    step();
    memory_read = 1'b0;
    checks++; if ({wb_cyc, wb_addr} !== {1'b1, 32'h0000_0504}) begin failures++; $display("FAIL b2b_b_req got=%h exp=100000504", {wb_cyc, wb_addr}); end
    wb_data_in = 32'h2222_2222; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    checks++; if ({memory_response, bus_error, read_data} !== {2'b10, 32'h2222_2222}) begin failures++; $display("FAIL b2b_b_data got=%h exp=222222222", {memory_response, bus_error, read_data}); end
    step();
  endtask

  task automatic test_both_and_stray();
    issue(1'b1, 1'b1, OPT_LW, 32'h0000_0600, 32'h5555_AAAA);
    checks++; if ({wb_cyc, wb_we, wb_data_out} !== {2'b11, 32'h5555_AAAA}) begin failures++; $display("FAIL both_we got=%h exp=35555aaaa", {wb_cyc, wb_we, wb_data_out}); end
    wb_ack = 1'b1; step(); wb_ack = 1'b0; step();
    wb_ack = 1'b1; step(); step();
    checks++; if ({memory_response, wb_cyc, bus_error} !== 3'b000) begin failures++; $display("FAIL stray_ack got=%b exp=000", {memory_response, wb_cyc, bus_error}); end
    wb_ack = 1'b0; step();
    checks++; if (memory_response !== 1'b0) begin failures++; $display("FAIL stray_after got=%b exp=0", memory_response); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_both_and_stray();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
